// File: rtl/ram16k_wb_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram16k_wb_ctrl : Wishbone B4 pipelined slave for a 16384x32 sleepable SRAM
// Revision: 1.0
// ---------------------------------------------------------------------------
module ram16k_wb_ctrl #(
  parameter int         IDLE_CYCLES = 64,
  parameter int         WAKE_CYCLES = 4,
  parameter logic [5:0] FUSE        = 6'b000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [13:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  input  logic        sleep_req_i,
  output logic        sleep_o,
  output logic [13:0] ram_ia_o,
  output logic [31:0] ram_i_o,
  output logic [31:0] ram_dm_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic        ram_slp_o,
  output logic [5:0]  ram_fo_o,
  input  logic [31:0] ram_a_i
);

  localparam int                IDLE_W     = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
  localparam int                IDLE_MAX_I = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_MAX_I);
  localparam logic [3:0]        WAKE_LAST  = 4'(WAKE_CYCLES - 1);
  localparam logic              AUTO_SLEEP = (IDLE_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_nx;
  logic [3:0]        wake_cnt, wake_cnt_nx;
  logic              ce, we, ack_pending, was_read;
  logic [13:0]       ia;
  logic [31:0]       wdat, dm, sel_mask;
  logic              req, accept, pipe_empty, idle_hit;

  assign req        = wb_cyc_i & wb_stb_i;
  assign accept     = req & (state == ST_ACTIVE);
  assign pipe_empty = ~ce & ~ack_pending;
  assign idle_hit   = AUTO_SLEEP & (idle_cnt == IDLE_MAX);

  generate
    for (genvar k = 0; k < 4; k++) begin : g_mask
      assign sel_mask[8*k +: 8] = {8{~wb_sel_i[k]}};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_ACTIVE;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      state    <= state_nx;
      idle_cnt <= idle_cnt_nx;
      wake_cnt <= wake_cnt_nx;
    end
  end

  // In ACTIVE any strobe is accepted, so a pending request always beats sleep entry.
  always_comb begin
    state_nx    = state;
    idle_cnt_nx = idle_cnt;
    wake_cnt_nx = wake_cnt;
    case (state)
      ST_ACTIVE: begin
        if (accept) begin
          idle_cnt_nx = '0;
        end else if (pipe_empty) begin
          if (idle_hit || sleep_req_i) begin
            state_nx = ST_SLEEP;
          end else if (AUTO_SLEEP && (idle_cnt != IDLE_MAX)) begin
            idle_cnt_nx = idle_cnt + 1'b1;
          end
        end
      end
      ST_SLEEP: begin
        if (req && !sleep_req_i) begin
          state_nx    = ST_WAKE;
          wake_cnt_nx = '0;
        end
      end
      ST_WAKE: begin
        if (wake_cnt == WAKE_LAST) begin
          state_nx    = ST_ACTIVE;
          idle_cnt_nx = '0;
          wake_cnt_nx = '0;
        end else begin
          wake_cnt_nx = wake_cnt + 1'b1;
        end
      end
      default: state_nx = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ce          <= 1'b0;
      we          <= 1'b0;
      ia          <= '0;
      wdat        <= '0;
      dm          <= '1;
      ack_pending <= 1'b0;
      was_read    <= 1'b0;
    end else begin
      ce          <= accept;
      we          <= accept & wb_we_i;
      ack_pending <= ce;
      was_read    <= ce & ~we;
      if (accept) begin
        ia   <= wb_adr_i;
        wdat <= wb_dat_i;
        dm   <= wb_we_i ? sel_mask : '1;
      end
    end
  end

  // A dropped cyc suppresses the ack, but a write already on the macro pins completes.
  assign wb_ack_o   = ack_pending & wb_cyc_i;
  assign wb_dat_o   = (wb_ack_o & was_read) ? ram_a_i : '0;
  assign wb_stall_o = (state != ST_ACTIVE);
  assign sleep_o    = (state == ST_SLEEP);
  assign ram_slp_o  = sleep_o;
  assign ram_ce_o   = ce;
  assign ram_we_o   = we;
  assign ram_ia_o   = ia;
  assign ram_i_o    = wdat;
  assign ram_dm_o   = dm;
  assign ram_fo_o   = FUSE;

endmodule
`default_nettype wire

// File: tb/tb_ram16k_wb_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ram16k_wb_ctrl : directed self-checking bench with a behavioural SRAM
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ram16k_wb_ctrl;
  localparam int         IDLE   = 8;
  localparam int         WAKE   = 4;
  localparam logic [5:0] FUSE_V = 6'b101101;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, sleep_req = 1'b0;
  logic [13:0] adr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat = '0;
  logic [31:0] wb_dat_o, ram_i_o, ram_dm_o, ram_a;
  logic        wb_ack_o, wb_stall_o, sleep_o, ram_ce_o, ram_we_o, ram_slp_o;
  logic [13:0] ram_ia_o;
  logic [5:0]  ram_fo_o;
  logic [31:0] mem [0:16383];

  int n_tests = 0, n_fail = 0;
  logic [31:0] rd, dm_seen;
  int          stalls;
  logic        ack_ok;

  ram16k_wb_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .FUSE(FUSE_V)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o), .sleep_req_i(sleep_req),
    .sleep_o(sleep_o), .ram_ia_o(ram_ia_o), .ram_i_o(ram_i_o), .ram_dm_o(ram_dm_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_slp_o(ram_slp_o),
    .ram_fo_o(ram_fo_o), .ram_a_i(ram_a)
  );

  always #5 clk = ~clk;

  // Macro model: masked write, read-before-write data one cycle after the CE edge.
  always @(posedge clk) begin
    if (ram_ce_o) begin
      if (ram_we_o) mem[ram_ia_o] <= (mem[ram_ia_o] & ram_dm_o) | (ram_i_o & ~ram_dm_o);
      ram_a <= mem[ram_ia_o];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic c, input logic s, input logic w, input logic [13:0] a,
                     input logic [3:0] sl, input logic [31:0] d);
    cyc = c; stb = s; we = w; adr = a; sel = sl; dat = d;
  endtask

  // One request: waits out stall (bounded), returns read data, stall count and mask seen.
  task automatic xfer(input logic w, input logic [13:0] a, input logic [3:0] sl,
                      input logic [31:0] d, output logic [31:0] rdata, output int nstall,
                      output logic [31:0] dms, output logic ok);
    drv(1'b1, 1'b1, w, a, sl, d);
    nstall = 0;
    @(negedge clk);
    while (wb_stall_o && nstall < 40) begin
      nstall++;
      @(negedge clk);
    end
    if (wb_stall_o) chk("stall_timeout", 32'(nstall), 32'd0);
    tick();
    stb = 1'b0;
    @(negedge clk);
    dms = ram_dm_o;
    ok  = ram_ce_o & ~wb_ack_o;
    tick();
    @(negedge clk);
    ok    = ok & wb_ack_o;
    rdata = wb_dat_o;
    tick();
    cyc = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_ce", 32'(ram_ce_o), 32'd0);
    chk("rst_we", 32'(ram_we_o), 32'd0);
    chk("rst_slp", 32'(ram_slp_o), 32'd0);
    chk("rst_ia", 32'(ram_ia_o), 32'd0);
    chk("rst_i", ram_i_o, 32'd0);
    chk("rst_dm", ram_dm_o, 32'hFFFF_FFFF);
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_sleep", 32'(sleep_o), 32'd0);
    chk("rst_stall", 32'(wb_stall_o), 32'd0);
    chk("fuse", 32'(ram_fo_o), 32'(FUSE_V));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Back-to-back: two writes then two reads on consecutive cycles
    drv(1, 1, 1, 14'h0010, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk); chk("b2b_stall0", 32'(wb_stall_o), 32'd0);
    tick();
    drv(1, 1, 1, 14'h3FFF, 4'hF, 32'h1234_5678);
    @(negedge clk);
    chk("b2b_stall1", 32'(wb_stall_o), 32'd0);
    chk("b2b_ce1", 32'(ram_ce_o), 32'd1);
    chk("b2b_we1", 32'(ram_we_o), 32'd1);
    chk("b2b_ia1", 32'(ram_ia_o), 32'h0010);
    chk("b2b_i1", ram_i_o, 32'hDEAD_BEEF);
    chk("b2b_dm1", ram_dm_o, 32'h0000_0000);
    tick();
    drv(1, 1, 0, 14'h0010, 4'hF, 32'h0);
    @(negedge clk);
    chk("b2b_stall2", 32'(wb_stall_o), 32'd0);
    chk("b2b_ack_w1", 32'(wb_ack_o), 32'd1);
    chk("b2b_dat_w1", wb_dat_o, 32'd0);
    chk("b2b_ia2", 32'(ram_ia_o), 32'h3FFF);
    tick();
    drv(1, 1, 0, 14'h3FFF, 4'hF, 32'h0);
    @(negedge clk);
    chk("b2b_stall3", 32'(wb_stall_o), 32'd0);
    chk("b2b_ack_w2", 32'(wb_ack_o), 32'd1);
    chk("b2b_we_rd", 32'(ram_we_o), 32'd0);
    chk("b2b_dm_rd", ram_dm_o, 32'hFFFF_FFFF);
    tick();
    drv(1, 0, 0, 14'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b_ack_r1", 32'(wb_ack_o), 32'd1);
    chk("b2b_dat_r1", wb_dat_o, 32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    chk("b2b_ack_r2", 32'(wb_ack_o), 32'd1);
    chk("b2b_dat_r2", wb_dat_o, 32'h1234_5678);
    chk("b2b_ce_idle", 32'(ram_ce_o), 32'd0);
    tick();
    @(negedge clk);
    chk("b2b_ack_end", 32'(wb_ack_o), 32'd0);
    drv(0, 0, 0, 14'h0, 4'h0, 32'h0);
    tick();

    // Byte mask
    xfer(1, 14'h0100, 4'hF, 32'hFFFF_FFFF, rd, stalls, dm_seen, ack_ok);
    chk("bm_fill_ack", 32'(ack_ok), 32'd1);
    xfer(1, 14'h0100, 4'b0101, 32'hAABB_CCDD, rd, stalls, dm_seen, ack_ok);
    chk("bm_dm", dm_seen, 32'hFF00_FF00);
    chk("bm_w_ack", 32'(ack_ok), 32'd1);
    xfer(0, 14'h0100, 4'hF, 32'h0, rd, stalls, dm_seen, ack_ok);
    chk("bm_rd", rd, 32'hFFBB_FFDD);
    chk("bm_r_ack", 32'(ack_ok), 32'd1);

    // Auto-sleep after IDLE idle cycles, then wake on a read
    repeat (IDLE - 1) tick();
    @(negedge clk);
    chk("as_not_yet", 32'(sleep_o), 32'd0);
    tick();
    @(negedge clk);
    chk("as_sleep", 32'(sleep_o), 32'd1);
    chk("as_slp", 32'(ram_slp_o), 32'd1);
    chk("as_ce", 32'(ram_ce_o), 32'd0);
    tick();
    drv(1, 1, 0, 14'h0010, 4'hF, 32'h0);
    @(negedge clk);
    chk("wk_stall_s", 32'(wb_stall_o), 32'd1);
    chk("wk_slp_s", 32'(ram_slp_o), 32'd1);
    tick();
    @(negedge clk);
    chk("wk_slp0", 32'(ram_slp_o), 32'd0);
    chk("wk_stall_w", 32'(wb_stall_o), 32'd1);
    chk("wk_ce_w", 32'(ram_ce_o), 32'd0);
    xfer(0, 14'h0010, 4'hF, 32'h0, rd, stalls, dm_seen, ack_ok);
    chk("wk_rem_stalls", 32'(stalls), 32'(WAKE - 1));
    chk("wk_ack", 32'(ack_ok), 32'd1);
    chk("wk_rd", rd, 32'hDEAD_BEEF);

    // Forced sleep: entry after the last ack, requests held stalled
    sleep_req = 1'b1;
    xfer(0, 14'h3FFF, 4'hF, 32'h0, rd, stalls, dm_seen, ack_ok);
    chk("fs_stalls0", 32'(stalls), 32'd0);
    chk("fs_rd", rd, 32'h1234_5678);
    @(negedge clk);
    chk("fs_after_ack", 32'(sleep_o), 32'd0);
    tick();
    @(negedge clk);
    chk("fs_sleep", 32'(sleep_o), 32'd1);
    tick();
    drv(1, 1, 0, 14'h3FFF, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fs_hold_stall", 32'(wb_stall_o), 32'd1);
      chk("fs_hold_ce", 32'(ram_ce_o), 32'd0);
      chk("fs_hold_sleep", 32'(sleep_o), 32'd1);
      tick();
    end
    sleep_req = 1'b0;
    xfer(0, 14'h3FFF, 4'hF, 32'h0, rd, stalls, dm_seen, ack_ok);
    chk("fs_wake_stalls", 32'(stalls), 32'(WAKE + 1));
    chk("fs_wake_rd", rd, 32'h1234_5678);

    // Abort: read ack dropped; write still lands
    drv(1, 1, 0, 14'h0010, 4'hF, 32'h0);
    @(negedge clk); chk("ab_r_stall", 32'(wb_stall_o), 32'd0);
    tick();
    drv(0, 0, 0, 14'h0, 4'h0, 32'h0);
    tick();
    @(negedge clk);
    chk("ab_r_ack", 32'(wb_ack_o), 32'd0);
    chk("ab_r_dat", wb_dat_o, 32'd0);
    tick();
    drv(1, 1, 1, 14'h0020, 4'hF, 32'h55AA_55AA);
    @(negedge clk); chk("ab_w_stall", 32'(wb_stall_o), 32'd0);
    tick();
    drv(0, 0, 0, 14'h0, 4'h0, 32'h0);
    @(negedge clk); chk("ab_w_ce", 32'(ram_ce_o), 32'd1);
    tick();
    @(negedge clk); chk("ab_w_ack", 32'(wb_ack_o), 32'd0);
    tick();
    xfer(0, 14'h0020, 4'hF, 32'h0, rd, stalls, dm_seen, ack_ok);
    chk("ab_readback", rd, 32'h55AA_55AA);

    // Reset with a request in flight
    drv(1, 1, 0, 14'h0010, 4'hF, 32'h0);
    @(negedge clk); chk("rf_stall", 32'(wb_stall_o), 32'd0);
    tick();
    drv(1, 0, 0, 14'h0, 4'h0, 32'h0);
    chk("rf_ce_pre", 32'(ram_ce_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rf_ce", 32'(ram_ce_o), 32'd0);
    chk("rf_ack", 32'(wb_ack_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    @(negedge clk); chk("rf_ack_post", 32'(wb_ack_o), 32'd0);

    // Reset during WAKE
    drv(0, 0, 0, 14'h0, 4'h0, 32'h0);
    sleep_req = 1'b1;
    tick();
    @(negedge clk); chk("rw_sleep", 32'(sleep_o), 32'd1);
    sleep_req = 1'b0;
    drv(1, 1, 0, 14'h3FFF, 4'hF, 32'h0);
    tick();
    chk("rw_in_wake_slp", 32'(ram_slp_o), 32'd0);
    chk("rw_in_wake_stall", 32'(wb_stall_o), 32'd1);
    rst_n = 1'b0;
    drv(0, 0, 0, 14'h0, 4'h0, 32'h0);
    #1;
    chk("rw_ack", 32'(wb_ack_o), 32'd0);
    chk("rw_ce", 32'(ram_ce_o), 32'd0);
    chk("rw_slp", 32'(ram_slp_o), 32'd0);
    chk("rw_stall", 32'(wb_stall_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    xfer(0, 14'h3FFF, 4'hF, 32'h0, rd, stalls, dm_seen, ack_ok);
    chk("rw_post_stalls", 32'(stalls), 32'd0);
    chk("rw_post_rd", rd, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
